winograd_output_transform_acc: RTL

Parametrised Winograd F(2x2,3x3) output transform with channel accumulation. It consumes a stream of 4x4 element-wise-product tiles M and computes Y = Aᵀ·M·A for each tile. It sums the 2x2 results over a run-time number of input channels, then rounds, shifts and saturates the sum. It sits between the element-wise multiplier array and the output buffer, uses valid/ready on both sides, and sustains one tile per cycle.

---
 rtl/wino_pkg.sv | 43 ++++
 rtl/wino_at_1d.sv | 36 +++
 rtl/winograd_output_transform_acc.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/wino_pkg.sv
// Shared definitions for the Winograd F(2x2,3x3) output transform.
//   AT         : transform coefficients, AT[i][k] multiplies input element k of output i
//   idx_m      : flat index of element (r,c) in a 4x4 tile (also used for the 2x4 T tile)
//   idx_y      : flat index of element (i,j) in a 2x2 result tile
//   acc_width  : accumulator width that cannot wrap for up to max_ch channels
//   sat_round  : optional round-half-up right shift, then signed saturation to ow bits
package wino_pkg;

    localparam int AT [2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};

    function automatic int idx_m(input int r, input int c);
        return 4 * r + c;
    endfunction

    function automatic int idx_y(input int i, input int j);
        return 2 * i + j;
    endfunction

    function automatic int acc_width(input int w, input int max_ch);
        return w + 4 + $clog2(max_ch);
    endfunction

    // Works on a 64-bit container so the rounding add cannot overflow the caller's width.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] s,
                                                     input int shift, input int ow);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = s;
        if (shift > 0) begin
            r = (s + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/wino_at_1d.sv
// One-dimensional A^T transform: four signed inputs to two signed outputs.
//   x : input k at slice [k*IW +: IW], signed
//   y : output i at slice [i*(IW+2) +: IW+2], signed; two bits of growth cover a
//       three-term sum with no wrap
module wino_at_1d
    import wino_pkg::*;
#(
    parameter int unsigned IW = 16
) (
    input  logic [4*IW-1:0]     x,
    output logic [2*(IW+2)-1:0] y
);

    localparam int unsigned OW1 = IW + 2;

    logic signed [OW1-1:0] xe [4];
    logic signed [OW1-1:0] s  [2];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            xe[k] = OW1'(signed'(x[k*IW +: IW]));
        end
        for (int i = 0; i < 2; i++) begin
            s[i] = '0;
            for (int k = 0; k < 4; k++) begin
                if (AT[i][k] == 1) begin
                    s[i] = s[i] + xe[k];
                end else if (AT[i][k] == -1) begin
                    s[i] = s[i] - xe[k];
                end
            end
        end
        y = {s[1], s[0]};
    end

endmodule

// File: rtl/winograd_output_transform_acc.sv
// Winograd F(2x2,3x3) output transform Y = A^T * M * A with accumulation over a
// run-time number of input channels, followed by rounding shift and saturation.
// Pipeline: stage 1 registers T = A^T*M (columns), stage 2 registers P = T*A (rows),
// the accumulate stage adds P into the running sum and loads Y on a group's last tile.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   cfg_ch               : channels per group, sampled with the group's first tile
//   in_valid/in_ready, M : input tile stream, element (r,c) at [(4r+c)*W +: W]
//   out_valid/out_ready,Y: result stream, element (i,j) at [(2i+j)*OW +: OW]
// Build option: define WOT_RELU_EN to force negative output lanes to zero.
module winograd_output_transform_acc
    import wino_pkg::*;
#(
    parameter int unsigned W      = 16,
    parameter int unsigned OW     = 16,
    parameter int unsigned MAX_CH = 64,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [$clog2(MAX_CH):0]   cfg_ch,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [16*W-1:0]           M,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*OW-1:0]           Y
);

    localparam int unsigned CW = $clog2(MAX_CH) + 1;
    localparam int unsigned TW = W + 2;
    localparam int unsigned PW = W + 4;
    localparam int unsigned AW = acc_width(W, MAX_CH);

    logic                 en;
    logic [4*W-1:0]       col  [4];
    logic [2*TW-1:0]      tcol [4];
    logic [8*TW-1:0]      t_d;
    logic [4*TW-1:0]      row  [2];
    logic [2*PW-1:0]      prow [2];
    logic [4*PW-1:0]      p_d;

    logic                 v1_q, v2_q;
    logic [8*TW-1:0]      t_q;
    logic [4*PW-1:0]      p_q;
    // cfg_ch travels with each tile so the first tile of a group carries its own count.
    logic [CW-1:0]        ch1_q, ch2_q;
    logic [CW-1:0]        cnt_q, tgt_q;
    logic signed [AW-1:0] acc_q [4];
    logic                 out_valid_q;
    logic [4*OW-1:0]      y_q;

    logic [CW-1:0]        ch_clamp, tgt_eff;
    logic                 last;
    logic signed [AW-1:0] sum [4];
    logic signed [63:0]   r;
    logic [4*OW-1:0]      y_conv;

    // Stall everything while a result is held and not taken.
    assign en        = !(out_valid_q && !out_ready);
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign Y         = y_q;

    // Stage 1: A^T applied down each column of M.
    for (genvar c = 0; c < 4; c++) begin : g_col
        assign col[c] = {M[idx_m(3, c)*W +: W], M[idx_m(2, c)*W +: W],
                         M[idx_m(1, c)*W +: W], M[idx_m(0, c)*W +: W]};
        wino_at_1d #(
            .IW (W)
        ) u_at_col (
            .x (col[c]),
            .y (tcol[c])
        );
        assign t_d[idx_m(0, c)*TW +: TW] = tcol[c][0 +: TW];
        assign t_d[idx_m(1, c)*TW +: TW] = tcol[c][TW +: TW];
    end

    // Stage 2: A applied along each row of T.
    for (genvar i = 0; i < 2; i++) begin : g_row
        assign row[i] = {t_q[idx_m(i, 3)*TW +: TW], t_q[idx_m(i, 2)*TW +: TW],
                         t_q[idx_m(i, 1)*TW +: TW], t_q[idx_m(i, 0)*TW +: TW]};
        wino_at_1d #(
            .IW (TW)
        ) u_at_row (
            .x (row[i]),
            .y (prow[i])
        );
        assign p_d[idx_y(i, 0)*PW +: PW] = prow[i][0 +: PW];
        assign p_d[idx_y(i, 1)*PW +: PW] = prow[i][PW +: PW];
    end

    always_comb begin
        if (ch2_q == '0) begin
            ch_clamp = CW'(1);
        end else if (ch2_q > CW'(MAX_CH)) begin
            ch_clamp = CW'(MAX_CH);
        end else begin
            ch_clamp = ch2_q;
        end
        tgt_eff = (cnt_q == '0) ? ch_clamp : tgt_q;
        last    = (cnt_q == tgt_eff - CW'(1));
        r       = '0;
        y_conv  = '0;
        for (int l = 0; l < 4; l++) begin
            sum[l] = acc_q[l] + AW'(signed'(p_q[l*PW +: PW]));
            r      = sat_round(64'(sum[l]), int'(SHIFT), int'(OW));
`ifdef WOT_RELU_EN
            if (r < 64'sd0) begin
                r = '0;
            end
`endif
            y_conv[l*OW +: OW] = r[OW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            t_q         <= '0;
            p_q         <= '0;
            ch1_q       <= '0;
            ch2_q       <= '0;
            cnt_q       <= '0;
            tgt_q       <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            for (int l = 0; l < 4; l++) begin
                acc_q[l] <= '0;
            end
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (en) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    t_q   <= t_d;
                    ch1_q <= cfg_ch;
                end
                v2_q <= v1_q;
                if (v1_q) begin
                    p_q   <= p_d;
                    ch2_q <= ch1_q;
                end
                if (v2_q) begin
                    if (cnt_q == '0) begin
                        tgt_q <= ch_clamp;
                    end
                    if (last) begin
                        // Overrides the handshake clear above when results are back-to-back.
                        y_q         <= y_conv;
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        for (int l = 0; l < 4; l++) begin
                            acc_q[l] <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        for (int l = 0; l < 4; l++) begin
                            acc_q[l] <= sum[l];
                        end
                    end
                end
            end
        end
    end

endmodule
